// File: rtl/seq_neural_net.sv
// Time-multiplexed fully-connected network: DEPTH layers of N neurons, one signed
// fixed-point MAC per cycle, loadable coefficient bank, per-vector activation.
module seq_neural_net #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int N     = 2,
    parameter int DEPTH = 2,
    localparam int NCOEF = DEPTH * N * N,
    localparam int AW    = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               coef_we,
    input  logic [AW-1:0]      coef_addr,
    input  logic [WIDTH-1:0]   coef_wdata,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [1:0]         act_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic               busy
);
    localparam int ACCW = 2 * WIDTH + $clog2(N) + 1;
    localparam int NW   = (N > 1) ? $clog2(N) : 1;
    localparam int LW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic signed [ACCW-1:0]  SMAX = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0]  SMIN = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1 << FRAC);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] coef_q    [NCOEF];
    logic signed [WIDTH-1:0] buf_cur_q [N];
    logic signed [WIDTH-1:0] buf_cur_d [N];
    logic signed [WIDTH-1:0] buf_nxt_q [N];
    logic signed [WIDTH-1:0] buf_nxt_d [N];
    logic signed [WIDTH-1:0] nxt_upd   [N];
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [NW-1:0]           src_q, src_d, neuron_q, neuron_d;
    logic [LW-1:0]           layer_q, layer_d;
    logic [1:0]              mode_q, mode_d;
    logic                    out_valid_q, out_valid_d;
    logic [N*WIDTH-1:0]      out_data_q, out_data_d;

    logic [AW-1:0]           cidx;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]  shifted;
    logic signed [WIDTH-1:0] r;
    logic                    coef_wr_ok;
    int unsigned             addr_ext;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_MAC) || (state_q == S_WB);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        addr_ext   = int'(coef_addr);
        coef_wr_ok = coef_we && (addr_ext < NCOEF) &&
                     (state_q == S_IDLE || state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCOEF; i++) coef_q[i] <= '0;
        end else if (coef_wr_ok) begin
            coef_q[coef_addr] <= coef_wdata;
        end
    end

    always_comb begin
        cidx = AW'((int'(layer_q) * N + int'(neuron_q)) * N + int'(src_q));
        prod = buf_cur_q[src_q] * coef_q[cidx];
        shifted = acc_q >>> FRAC;
        if (shifted > SMAX)      r = SMAX[WIDTH-1:0];
        else if (shifted < SMIN) r = SMIN[WIDTH-1:0];
        else                     r = shifted[WIDTH-1:0];
        case (mode_q)
            2'd1:    if (r < 0) r = '0;
            2'd2:    r = (r > 0) ? ONE : '0;
            default: ;
        endcase
        nxt_upd           = buf_nxt_q;
        nxt_upd[neuron_q] = r;
    end

    always_comb begin
        state_d     = state_q;
        buf_cur_d   = buf_cur_q;
        buf_nxt_d   = buf_nxt_q;
        acc_d       = acc_q;
        src_d       = src_q;
        neuron_d    = neuron_q;
        layer_d     = layer_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                for (int unsigned i = 0; i < N; i++) buf_cur_d[i] = in_data[i*WIDTH +: WIDTH];
                mode_d   = act_mode;
                src_d    = '0;
                neuron_d = '0;
                layer_d  = '0;
                acc_d    = '0;
                state_d  = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + ACCW'(prod);
                if (src_q == NW'(N - 1)) begin
                    src_d   = '0;
                    state_d = S_WB;
                end else begin
                    src_d = src_q + 1'b1;
                end
            end
            S_WB: begin
                buf_nxt_d = nxt_upd;
                acc_d     = '0;
                if (neuron_q != NW'(N - 1)) begin
                    neuron_d = neuron_q + 1'b1;
                    state_d  = S_MAC;
                end else if (layer_q != LW'(DEPTH - 1)) begin
                    // nxt_upd already holds this neuron's result, so it becomes the next layer's input
                    buf_cur_d = nxt_upd;
                    layer_d   = layer_q + 1'b1;
                    neuron_d  = '0;
                    state_d   = S_MAC;
                end else begin
                    for (int unsigned i = 0; i < N; i++) out_data_d[i*WIDTH +: WIDTH] = nxt_upd[i];
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int unsigned i = 0; i < N; i++) begin
                buf_cur_q[i] <= '0;
                buf_nxt_q[i] <= '0;
            end
            acc_q       <= '0;
            src_q       <= '0;
            neuron_q    <= '0;
            layer_q     <= '0;
            mode_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_cur_q   <= buf_cur_d;
            buf_nxt_q   <= buf_nxt_d;
            acc_q       <= acc_d;
            src_q       <= src_d;
            neuron_q    <= neuron_d;
            layer_q     <= layer_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_seq_neural_net.sv
// Directed bench for seq_neural_net at WIDTH=16, FRAC=8, N=2, DEPTH=2.
module tb_seq_neural_net;
    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int N     = 2;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n, coef_we, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic [31:0] in_data, out_data;
    logic [1:0]  act_mode;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int          lat;
    logic [31:0] res, held;

    localparam logic [127:0] GOLDEN = {16'h0100, 16'h0000, 16'h0000, 16'h0100,
                                       16'hFF00, 16'h0100, 16'h0100, 16'h0100};
    localparam logic [127:0] SATC   = {8{16'h0200}};

    always #5 clk = ~clk;

    seq_neural_net #(.WIDTH(WIDTH), .FRAC(FRAC), .N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .act_mode(act_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wcoef(input logic [2:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic load(input logic [127:0] c);
        for (int i = 0; i < 8; i++) wcoef(3'(i), c[i*16 +: 16]);
    endtask

    // Accept one vector; act_mode is disturbed afterwards to prove it was latched.
    task automatic start_vec(input logic [15:0] x0, input logic [15:0] x1, input logic [1:0] m);
        in_data = {x1, x0}; act_mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; act_mode = 2'd3;
        check("accepted_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_out(output int l, output logic [31:0] o);
        l = 0;
        while (!out_valid && l < 100) begin
            @(posedge clk); #1;
            l++;
        end
        o = out_data;
    endtask

    task automatic run_vec(input string tag, input logic [15:0] x0, input logic [15:0] x1,
                           input logic [1:0] m, input logic [31:0] exp);
        int          l;
        logic [31:0] o;
        start_vec(x0, x1, m);
        wait_out(l, o);
        check({tag, "_out"}, o, exp);
        check({tag, "_latency"}, 32'(l), 32'd12);
        @(posedge clk); #1;
        check({tag, "_ready_after"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        in_valid = 1'b0; in_data = '0; act_mode = '0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_out_data",  out_data,           32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        load(GOLDEN);
        run_vec("linear", 16'h0100, 16'h0200, 2'd0, 32'hFF00_0300);
        run_vec("relu",   16'h0100, 16'h0200, 2'd1, 32'h0000_0300);
        run_vec("step",   16'h0100, 16'h0200, 2'd2, 32'h0000_0100);

        // Write during MAC must be ignored
        start_vec(16'h0100, 16'h0200, 2'd0);
        @(posedge clk); #1;
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'h0500;
        @(posedge clk); #1;
        coef_we = 1'b0;
        wait_out(lat, res);
        check("gate_mac_out", res, 32'hFF00_0300);
        @(posedge clk); #1;

        wcoef(3'd0, 16'h0500);
        run_vec("gate_idle", 16'h0100, 16'h0200, 2'd0, 32'hFF00_0700);

        // Write and accept in the same cycle: the new coefficient applies
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'h0100;
        start_vec(16'h0100, 16'h0200, 2'd0);
        coef_we = 1'b0;
        wait_out(lat, res);
        check("same_cycle_out", res, 32'hFF00_0300);
        @(posedge clk); #1;

        // Backpressure
        out_ready = 1'b0;
        start_vec(16'h0100, 16'h0200, 2'd0);
        wait_out(lat, held);
        check("bp_out", held, 32'hFF00_0300);
        in_data = {16'h0100, 16'h0100}; act_mode = 2'd0; in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
            check("bp_data_hold",  out_data,           held);
            check("bp_in_ready",   {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {30'd0, in_ready, out_valid}, 32'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accept", {31'd0, busy}, 32'd1);
        wait_out(lat, res);
        check("bp_next_out", res, 32'h0000_0200);
        check("bp_next_latency", 32'(lat), 32'd12);
        @(posedge clk); #1;

        load(SATC);
        run_vec("sat_pos", 16'h7F00, 16'h7F00, 2'd0, 32'h7FFF_7FFF);
        run_vec("sat_neg", 16'h8000, 16'h8000, 2'd0, 32'h8000_8000);

        // Reset in the middle of MAC
        load(GOLDEN);
        start_vec(16'h0100, 16'h0200, 2'd0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        check("midrst_busy",      {31'd0, busy},      32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_vec("post_rst", 16'h0100, 16'h0200, 2'd0, 32'h0000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
